// File: rtl/data_mem_interface_pkg.sv
// Shared types and constants for the byte-lane data memory interface.
package data_mem_interface_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_CAPT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  localparam logic [LANES-1:0] MASK_B = 4'b0001;
  localparam logic [LANES-1:0] MASK_H = 4'b0011;
  localparam logic [LANES-1:0] MASK_W = 4'b1111;

  // Request fields held for the duration of one access.
  typedef struct packed {
    logic              wr;
    size_t             size;
    logic [1:0]        off;
    logic              split;
    logic [DATA_W-1:0] data;
  } req_lat_t;

  function automatic logic [LANES-1:0] size_mask(input size_t sz);
    case (sz)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = '0;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input size_t sz);
    case (sz)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      SZ_W:    size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_interface_if.sv
// Request/response and RAM-side bundle of the data memory interface.
interface data_mem_interface_if
  import data_mem_interface_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic              req_b_e;
  logic              req_h_e;
  logic              req_w_e;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_w;
  logic [15:0]       req_h;
  logic [7:0]        req_b;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [LANES-1:0]  ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_wr, req_b_e, req_h_e, req_w_e, req_addr, req_w, req_h, req_b,
    input  ram_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_wr, req_b_e, req_h_e, req_w_e, req_addr, req_w, req_h, req_b,
    output ram_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

endinterface

// File: rtl/data_mem_interface_byte_lane_aligner.sv
// Combinational lane steering: store data/enables into a two-word window,
// and load data from a two-word window back to a right-justified value.
module byte_lane_aligner
  import data_mem_interface_pkg::*;
(
  input  logic [1:0]          off,
  input  size_t               size,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W-1:0]   ld_hi,
  input  logic [DATA_W-1:0]   ld_lo,
  output logic [2*LANES-1:0]  be64,
  output logic [2*DATA_W-1:0] wdata64,
  output logic [DATA_W-1:0]   ld_data
);

  logic [2*DATA_W-1:0] ld_shifted;
  logic [LANES-1:0]    lane_mask;

  always_comb begin
    lane_mask  = size_mask(size);
    be64       = {4'b0000, lane_mask} << off;
    wdata64    = {32'h0, st_data} << {off, 3'b000};
    ld_shifted = {ld_hi, ld_lo} >> {off, 3'b000};
    for (int i = 0; i < int'(LANES); i++) begin
      ld_data[8*i +: 8] = ld_shifted[8*i +: 8] & {8{lane_mask[i]}};
    end
  end

endmodule

// File: rtl/data_mem_interface.sv
// Byte/half/word load-store front end for a single-port word RAM; splits
// word-straddling accesses into two beats and returns zero-extended load data.
module data_mem_interface
  import data_mem_interface_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
)(
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_interface_if.slave  bus
);

  state_t              state_q, state_d;
  req_lat_t            req_q;
  logic [ADDR_W-1:0]   a_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  size_t               req_size;
  logic [DATA_W-1:0]   req_data;
  logic                req_split;
  logic                accept;

  logic [2*LANES-1:0]  be64;
  logic [2*DATA_W-1:0] wdata64;
  logic [DATA_W-1:0]   ld_hi, ld_lo, ld_data;

  logic                ready, rsp_valid, ram_en, ram_we;
  logic [LANES-1:0]    ram_be;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;

  // Address bits above the RAM window are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  // Size decode, priority word > half > byte.
  always_comb begin
    req_size = SZ_NONE;
    req_data = '0;
    if (bus.req_w_e) begin
      req_size = SZ_W;
      req_data = bus.req_w;
    end else if (bus.req_h_e) begin
      req_size = SZ_H;
      req_data = 32'(bus.req_h);
    end else if (bus.req_b_e) begin
      req_size = SZ_B;
      req_data = 32'(bus.req_b);
    end
  end

  assign req_split = ({1'b0, bus.req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
  assign accept    = (state_q == ST_IDLE) && bus.req_valid;

  // Non-split loads take the fresh RAM word as the low half.
  assign ld_hi = req_q.split ? bus.ram_rdata : '0;
  assign ld_lo = req_q.split ? lo_q : bus.ram_rdata;

  byte_lane_aligner u_aligner (
    .off     (req_q.off),
    .size    (req_q.size),
    .st_data (req_q.data),
    .ld_hi   (ld_hi),
    .ld_lo   (ld_lo),
    .be64    (be64),
    .wdata64 (wdata64),
    .ld_data (ld_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.req_valid) state_d = (req_size == SZ_NONE) ? ST_RESP : ST_BEAT0;
      ST_BEAT0: state_d = req_q.split ? ST_BEAT1 : ST_CAPT;
      ST_BEAT1: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; RAM strobes fall with the async reset of state_q.
  always_comb begin
    ready     = 1'b0;
    rsp_valid = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      ST_IDLE:  ready = 1'b1;
      ST_BEAT0: begin
        ram_en    = 1'b1;
        ram_we    = req_q.wr;
        ram_be    = be64[LANES-1:0];
        ram_addr  = a_q;
        ram_wdata = wdata64[DATA_W-1:0];
      end
      ST_BEAT1: begin
        ram_en    = 1'b1;
        ram_we    = req_q.wr;
        ram_be    = be64[2*LANES-1:LANES];
        ram_addr  = a_q + ADDR_W'(1);
        ram_wdata = wdata64[2*DATA_W-1:DATA_W];
      end
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Request latch, low-beat capture and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      a_q         <= '0;
      lo_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q       <= '{wr: bus.req_wr, size: req_size, off: bus.req_addr[1:0],
                         split: req_split, data: req_data};
        a_q         <= bus.req_addr[ADDR_W+1:2];
        lo_q        <= '0;
        rsp_rdata_q <= '0;
        rsp_err_q   <= (req_size == SZ_NONE);
      end
      if (state_q == ST_BEAT1) lo_q <= bus.ram_rdata;
      if (state_q == ST_CAPT) begin
        if (!req_q.split) lo_q <= bus.ram_rdata;
        rsp_rdata_q <= req_q.wr ? '0 : ld_data;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_be    = ram_be;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;

endmodule

// File: tb/tb_data_mem_interface.sv
// Directed bench for data_mem_interface with a behavioural 1-cycle RAM and a
// response scoreboard.
module tb_data_mem_interface;

  localparam int unsigned ADDR_W = 10;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exp_t sb[$];

  int          nbeats;
  logic [31:0] b_addr [2];
  logic [31:0] b_be   [2];
  logic [31:0] b_wd   [2];
  logic [31:0] b_we   [2];

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  data_mem_interface_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_interface #(.ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-before-write, one cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      if (bus.ram_we) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.ram_be[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input int nb, input logic [31:0] addr,
                           input logic [31:0] data);
    @(negedge clk);
    bus.req_wr    = wr;
    bus.req_b_e   = (nb == 1);
    bus.req_h_e   = (nb == 2);
    bus.req_w_e   = (nb == 4);
    bus.req_addr  = addr;
    bus.req_w     = data;
    bus.req_h     = data[15:0];
    bus.req_b     = data[7:0];
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_b_e   = 1'b0;
    bus.req_h_e   = 1'b0;
    bus.req_w_e   = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic wr, input int nb,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat);
    exp_t e;
    bit   got;
    sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
    drive_req(wr, nb, addr, data);
    nbeats = 0;
    got    = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (bus.ram_en) begin
        if (nbeats < 2) begin
          b_addr[nbeats] = 32'(bus.ram_addr);
          b_be[nbeats]   = 32'(bus.ram_be);
          b_wd[nbeats]   = bus.ram_wdata;
          b_we[nbeats]   = 32'(bus.ram_we);
        end
        nbeats++;
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        e   = sb.pop_front();
        chk({tag, " latency"}, 32'(c), 32'(e.lat));
        chk({tag, " rdata"}, bus.rsp_rdata, e.rdata);
        chk({tag, " err"}, 32'(bus.rsp_err), 32'(e.err));
      end
    end
    if (!got) begin
      chk({tag, " response timeout"}, 32'(got), 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    chk({tag, " single pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " ready after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int seen_rsp;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_b_e   = 1'b0;
    bus.req_h_e   = 1'b0;
    bus.req_w_e   = 1'b0;
    bus.req_addr  = '0;
    bus.req_w     = '0;
    bus.req_h     = '0;
    bus.req_b     = '0;

    // Reset state, with a request presented during reset.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_w_e   = 1'b1;
    @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst ram_be", 32'(bus.ram_be), 32'd0);
    chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst ram_wdata", bus.ram_wdata, 32'd0);
    bus.req_valid = 1'b0;
    bus.req_w_e   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst idle", 32'(bus.ram_en), 32'd0);

    // Aligned word store then load.
    run_req("st_w 0x40", 1'b1, 4, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    chk("st_w beats", 32'(nbeats), 32'd1);
    chk("st_w addr", b_addr[0], 32'h10);
    chk("st_w be", b_be[0], 32'hF);
    chk("st_w wdata", b_wd[0], 32'hDEADBEEF);
    chk("st_w we", b_we[0], 32'd1);
    run_req("ld_w 0x40", 1'b0, 4, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    chk("ld_w beats", 32'(nbeats), 32'd1);
    chk("ld_w we", b_we[0], 32'd0);

    // Byte store into an existing word, then reads of the merged word.
    run_req("st_w 0x40 base", 1'b1, 4, 32'h40, 32'h11223344, 32'h0, 1'b0, 3);
    run_req("st_b 0x43", 1'b1, 1, 32'h43, 32'h000000A5, 32'h0, 1'b0, 3);
    chk("st_b be", b_be[0], 32'h8);
    chk("st_b wdata", b_wd[0], 32'hA5000000);
    run_req("ld_w hi-addr alias", 1'b0, 4, 32'hABC00040, 32'h0, 32'hA5223344, 1'b0, 3);
    run_req("ld_b 0x43", 1'b0, 1, 32'h43, 32'h0, 32'h000000A5, 1'b0, 3);
    run_req("ld_h 0x42", 1'b0, 2, 32'h42, 32'h0, 32'h0000A522, 1'b0, 3);

    // Halfword straddling words 0x11/0x12.
    run_req("st_h 0x47", 1'b1, 2, 32'h47, 32'h0000BEEF, 32'h0, 1'b0, 4);
    chk("st_h beats", 32'(nbeats), 32'd2);
    chk("st_h b0 addr", b_addr[0], 32'h11);
    chk("st_h b0 be", b_be[0], 32'h8);
    chk("st_h b0 byte3", 32'(b_wd[0][31:24]), 32'hEF);
    chk("st_h b1 addr", b_addr[1], 32'h12);
    chk("st_h b1 be", b_be[1], 32'h1);
    chk("st_h b1 byte0", 32'(b_wd[1][7:0]), 32'hBE);
    run_req("ld_h 0x47", 1'b0, 2, 32'h47, 32'h0, 32'h0000BEEF, 1'b0, 4);

    // Split word load wrapping from the last RAM word to word 0.
    run_req("st_w top", 1'b1, 4, 32'hFFC, 32'hAABBCCDD, 32'h0, 1'b0, 3);
    run_req("st_w zero", 1'b1, 4, 32'h000, 32'h55667788, 32'h0, 1'b0, 3);
    run_req("ld_w wrap", 1'b0, 4, 32'hFFE, 32'h0, 32'h7788AABB, 1'b0, 4);
    chk("wrap b0 addr", b_addr[0], 32'h3FF);
    chk("wrap b0 be", b_be[0], 32'hC);
    chk("wrap b1 addr", b_addr[1], 32'h000);
    chk("wrap b1 be", b_be[1], 32'h3);

    // No size enable: immediate error response, no RAM traffic.
    run_req("no size", 1'b0, 0, 32'h40, 32'h0, 32'h0, 1'b1, 1);
    chk("no size beats", 32'(nbeats), 32'd0);

    // Reset during beat 1 of a split store.
    drive_req(1'b1, 2, 32'h0B, 32'h00001234);
    @(negedge clk);
    chk("abort b0 en", 32'(bus.ram_en), 32'd1);
    chk("abort b0 addr", 32'(bus.ram_addr), 32'h2);
    @(negedge clk);
    chk("abort b1 en", 32'(bus.ram_en), 32'd1);
    chk("abort b1 addr", 32'(bus.ram_addr), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("abort en drop", 32'(bus.ram_en), 32'd0);
    chk("abort we drop", 32'(bus.ram_we), 32'd0);
    seen_rsp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp++;
    end
    chk("abort no rsp", 32'(seen_rsp), 32'd0);
    chk("abort ready", 32'(bus.req_ready), 32'd1);
    run_req("ld_b beat0 kept", 1'b0, 1, 32'h0B, 32'h0, 32'h00000034, 1'b0, 3);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
